// File: rtl/cnn_pkg.sv
// Shared float32 types and helpers for the CNN streaming blocks.
package cnn_pkg;
    localparam int FP32_WIDTH = 32;
    localparam logic [FP32_WIDTH-1:0] FP32_POS_ZERO = 32'h00000000;

    typedef logic [FP32_WIDTH-1:0] fp32_t;

    function automatic logic fp32_sign(input fp32_t x);
        return x[FP32_WIDTH-1];
    endfunction
endpackage

// File: rtl/maxpool2x2_stream_if.sv
// Pixel-in / pooled-word-out stream bundle for maxpool2x2_stream.
interface maxpool2x2_stream_if #(parameter int DATA_WIDTH = 32);
    logic                  valid_in;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  valid_out;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  frame_done;

    modport master (output valid_in, data_in, input valid_out, data_out, frame_done);
    modport slave  (input valid_in, data_in, output valid_out, data_out, frame_done);
endinterface

// File: rtl/fp32_max.sv
// Combinational float32 max on raw bits; +0/-0 compare equal and ties return a.
module fp32_max
    import cnn_pkg::*;
(
    input  fp32_t a,
    input  fp32_t b,
    output fp32_t y
);
    logic                  sa, sb;
    logic [FP32_WIDTH-2:0] ma, mb;

    assign sa = fp32_sign(a);
    assign sb = fp32_sign(b);
    assign ma = a[FP32_WIDTH-2:0];
    assign mb = b[FP32_WIDTH-2:0];

    always_comb begin
        y = a;
        if (sa != sb) begin
            // Opposite signs: the non-negative one wins unless both are zeros.
            if (!(ma == '0 && mb == '0) && sa)
                y = b;
        end else if (!sa) begin
            if (mb > ma)
                y = b;
        end else begin
            if (mb < ma)
                y = b;
        end
    end
endmodule

// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 stride-2 float32 max-pool over a raster pixel stream, no backpressure.
// Define MAXPOOL_RELU_EN to clamp negative pooled results (including -0) to +0.
module maxpool2x2_stream
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH = FP32_WIDTH,
    parameter int WIDTH      = 56,
    parameter int HEIGHT     = 56
) (
    input logic                 clk,
    input logic                 rst,
    maxpool2x2_stream_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);
    localparam int RW = $clog2(HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

    logic [CW-1:0]         col;
    logic [RW-1:0]         row;
    logic [DATA_WIDTH-1:0] pair_reg;
    logic [DATA_WIDTH-1:0] linebuf [WIDTH/2];
    fp32_t                 hmax, vmax, pooled;
    logic                  valid_out_q, frame_done_q;
    logic [DATA_WIDTH-1:0] data_out_q;

    fp32_max u_hmax (.a(pair_reg),             .b(bus.data_in), .y(hmax));
    fp32_max u_vmax (.a(linebuf[col[CW-1:1]]), .b(hmax),        .y(vmax));

`ifdef MAXPOOL_RELU_EN
    assign pooled = fp32_sign(vmax) ? FP32_POS_ZERO : vmax;
`else
    assign pooled = vmax;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col          <= '0;
            row          <= '0;
            pair_reg     <= '0;
            valid_out_q  <= 1'b0;
            frame_done_q <= 1'b0;
            data_out_q   <= '0;
        end else begin
            valid_out_q  <= 1'b0;
            frame_done_q <= 1'b0;
            if (bus.valid_in) begin
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
                if (!col[0]) begin
                    pair_reg <= bus.data_in;
                end else if (row[0]) begin
                    valid_out_q  <= 1'b1;
                    data_out_q   <= pooled;
                    frame_done_q <= (row == ROW_LAST) && (col == COL_LAST);
                end
            end
        end
    end

    // Even-row horizontal maxima wait here for the matching odd row; never read before rewritten.
    always_ff @(posedge clk) begin
        if (bus.valid_in && col[0] && !row[0])
            linebuf[col[CW-1:1]] <= hmax;
    end

    assign bus.valid_out  = valid_out_q;
    assign bus.data_out   = data_out_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Directed bench for maxpool2x2_stream: a 4x4 instance for window/latency cases, a 56x56 one for frames.
module tb_maxpool2x2_stream;
    import cnn_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    maxpool2x2_stream_if if4 ();
    maxpool2x2_stream_if if56 ();

    maxpool2x2_stream #(.DATA_WIDTH(32), .WIDTH(4),  .HEIGHT(4))  dut4  (.clk(clk), .rst(rst), .bus(if4.slave));
    maxpool2x2_stream #(.DATA_WIDTH(32), .WIDTH(56), .HEIGHT(56)) dut56 (.clk(clk), .rst(rst), .bus(if56.slave));

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] q_data[$];
    int          q_cyc[$];
    logic        q_fd[$];
    logic [31:0] out56[$];
    int          fd56[$];
    int          n56 = 0;
    int          in_cyc[16];

    logic [31:0] ramp[16] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                              32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000,
                              32'h41100000, 32'h41200000, 32'h41300000, 32'h41400000,
                              32'h41500000, 32'h41600000, 32'h41700000, 32'h41800000};
    logic [31:0] exp_ramp[4] = '{32'h40C00000, 32'h41000000, 32'h41600000, 32'h41800000};
    int          exp_idx[4]  = '{5, 7, 13, 15};

    always @(negedge clk) begin
        if (if4.valid_out) begin
            q_data.push_back(if4.data_out);
            q_cyc.push_back(cyc);
            q_fd.push_back(if4.frame_done);
        end
        if (if56.valid_out) begin
            out56.push_back(if56.data_out);
            if (if56.frame_done) fd56.push_back(n56);
            n56++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic clear4();
        q_data.delete();
        q_cyc.delete();
        q_fd.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1 if4.valid_in = 1'b0;
            if56.valid_in = 1'b0;
        end
    endtask

    task automatic send4(input logic [31:0] d, input int gap, input int idx);
        if (gap > 0) idle(gap);
        @(posedge clk);
        #1 if4.valid_in = 1'b1;
        if4.data_in = d;
        if (idx >= 0) in_cyc[idx] = cyc;
    endtask

    task automatic send_frame4(input logic [31:0] px[16], input int maxgap);
        for (int i = 0; i < 16; i++)
            send4(px[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0, i);
        idle(3);
    endtask

    task automatic check_fd_count(input string tag, input int expv);
        int n = 0;
        foreach (q_fd[i]) if (q_fd[i]) n++;
        check(tag, 32'(n), 32'(expv));
    endtask

    function automatic logic [31:0] px56(input int f, input int r, input int c);
        return 32'h3F800000 + 32'((((f * 3136) + (r * 56) + c) * 7919) % 65521);
    endfunction

    function automatic logic [31:0] win56(input int f, input int wr, input int wc);
        logic [31:0] m = '0;
        for (int dr = 0; dr < 2; dr++)
            for (int dc = 0; dc < 2; dc++)
                if (px56(f, 2*wr + dr, 2*wc + dc) > m) m = px56(f, 2*wr + dr, 2*wc + dc);
        return m;
    endfunction

    logic [31:0] frm[16];

    initial begin
        if4.valid_in  = 1'b0;
        if4.data_in   = '0;
        if56.valid_in = 1'b0;
        if56.data_in  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid_out", {31'b0, if4.valid_out}, 32'd0);
        check("rst_data_out", if4.data_out, 32'd0);
        check("rst_frame_done", {31'b0, if4.frame_done}, 32'd0);
        check("rst_valid_out56", {31'b0, if56.valid_out}, 32'd0);
        rst = 1'b0;

        // Continuous 4x4 ramp: values, one-cycle latency, frame_done on the last word.
        clear4();
        send_frame4(ramp, 0);
        check("ramp_cnt", 32'(q_data.size()), 32'd4);
        for (int k = 0; k < 4 && k < q_data.size(); k++) begin
            check($sformatf("ramp_val%0d", k), q_data[k], exp_ramp[k]);
            check($sformatf("ramp_lat%0d", k), 32'(q_cyc[k]), 32'(in_cyc[exp_idx[k]] + 1));
            check($sformatf("ramp_fd%0d", k), {31'b0, q_fd[k]}, (k == 3) ? 32'd1 : 32'd0);
        end

        // All-negative first window.
        frm = ramp;
        frm[0] = 32'hBF800000; frm[1] = 32'hC0400000; frm[4] = 32'hBF000000; frm[5] = 32'hC0000000;
        clear4();
        send_frame4(frm, 0);
        check("neg_cnt", 32'(q_data.size()), 32'd4);
`ifdef MAXPOOL_RELU_EN
        if (q_data.size() > 0) check("neg_win", q_data[0], 32'h00000000);
`else
        if (q_data.size() > 0) check("neg_win", q_data[0], 32'hBF000000);
`endif
        if (q_data.size() > 3) check("neg_last", q_data[3], 32'h41800000);

        // +0 / -0 tie keeps the first operand.
        frm = ramp;
        frm[0] = 32'h00000000; frm[1] = 32'h80000000; frm[4] = 32'hBF800000; frm[5] = 32'hC0000000;
        clear4();
        send_frame4(frm, 0);
        check("zero_cnt", 32'(q_data.size()), 32'd4);
        if (q_data.size() > 0) check("zero_tie", q_data[0], 32'h00000000);

        // Ramp with random 0-3 cycle gaps on valid_in.
        clear4();
        send_frame4(ramp, 3);
        check("gap_cnt", 32'(q_data.size()), 32'd4);
        for (int k = 0; k < 4 && k < q_data.size(); k++)
            check($sformatf("gap_val%0d", k), q_data[k], exp_ramp[k]);
        check_fd_count("gap_fd_cnt", 1);
        if (q_fd.size() == 4) check("gap_fd_last", {31'b0, q_fd[3]}, 32'd1);

        // Reset after 7 pixels: only the window completed at pixel 6 emerges, then a clean frame.
        clear4();
        for (int i = 0; i < 7; i++) send4(ramp[i] + 32'h01000000, 0, -1);
        idle(2);
        check("part_cnt", 32'(q_data.size()), 32'd1);
        if (q_data.size() > 0) check("part_val", q_data[0], 32'h41C00000);
        check_fd_count("part_fd", 0);
        @(posedge clk);
        #1 rst = 1'b1;
        #2;
        check("midrst_data_out", if4.data_out, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        clear4();
        idle(2);
        check("post_rst_quiet", 32'(q_data.size()), 32'd0);
        send_frame4(ramp, 0);
        check("fresh_cnt", 32'(q_data.size()), 32'd4);
        for (int k = 0; k < 4 && k < q_data.size(); k++)
            check($sformatf("fresh_val%0d", k), q_data[k], exp_ramp[k]);
        check_fd_count("fresh_fd_cnt", 1);

        // Two back-to-back 56x56 frames.
        for (int f = 0; f < 2; f++)
            for (int r = 0; r < 56; r++)
                for (int c = 0; c < 56; c++) begin
                    @(posedge clk);
                    #1 if56.valid_in = 1'b1;
                    if56.data_in = px56(f, r, c);
                end
        idle(3);
        check("f56_cnt", 32'(out56.size()), 32'd1568);
        for (int k = 0; k < out56.size() && k < 1568; k++)
            check($sformatf("f56_val%0d", k), out56[k], win56(k / 784, (k % 784) / 28, k % 28));
        check("f56_fd_cnt", 32'(fd56.size()), 32'd2);
        if (fd56.size() > 0) check("f56_fd0", 32'(fd56[0]), 32'd783);
        if (fd56.size() > 1) check("f56_fd1", 32'(fd56[1]), 32'd1567);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
